acc_cpu_core: RTL and testbench
===============================

// Module: acc_cpu_core
// PURPOSE
//  Parametrised multicycle register-file CPU core: generalised width/regs/RAM, proper FSM, valid/ready issue, flags.
//  Accepts one instruction word per handshake; executes ALU, shift, load/store and conditional-jump ops.
//  Owns an internal register file and synchronous data RAM. Exposes PC, flags and a debug register read port.
// PARAMETERS
//  DW         8   data/register/PC width in bits (>=4)
//  NREG       4   number of registers (power of 2, >=2); RAW = clog2(NREG)
//  RAM_DEPTH  16  data RAM words (power of 2, <= 2**DW); MAW = clog2(RAM_DEPTH)
//  IW derived = 4 + 2*RAW + DW (default 16); SW = clog2(DW)
// PORTS
//  CLK          in   1    clock, all state on rising edge
//  RESET        in   1    asynchronous, active-high reset
//  instr        in   IW   {op[3:0], rd[RAW], rs[RAW], imm[DW]}
//  instr_valid  in   1    instr presented
//  instr_ready  out  1    core can accept (high only in IDLE)
//  pc           out  DW   program counter
//  zero         out  1    zero flag
//  carry        out  1    carry/borrow flag
//  busy         out  1    high in any state except IDLE
//  retire       out  1    one-cycle pulse when an instruction completes
//  dbg_sel      in   RAW  debug register select
//  dbg_data     out  DW   regfile[dbg_sel], combinational
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=0, zero=0, carry=0, retire=0, all registers=0, instr_ready=1, busy=0. RAM not cleared.
//  FSM: IDLE -(valid&ready)-> DECODE -> EXEC -> [MEM if LD] -> WB -> IDLE.
//   Accept latches instr into internal IR; instr/valid ignored outside IDLE (no queuing).
//   DECODE reads rd/rs operands. EXEC computes result and flags. MEM issues RAM read (1-cycle synchronous).
//   WB writes rd (if op writes), updates pc, pulses retire. Latency accept->retire: 3 cycles; LD: 4 cycles.
//  Opcodes (res = DW-bit result, wraps modulo 2**DW):
//   0 LDI rd=imm          1 MOV rd=rs           2 ADD rd=rd+rs, carry=carry-out
//   3 SUB rd=rd-rs, carry=borrow (rd<rs unsigned)  4 AND rd=rd&rs   5 OR rd=rd|rs
//   6 SRL rd=rs>>imm[SW-1:0] logical, zero-fill    7 ST RAM[imm[MAW-1:0]]=rd (no reg write)
//   8 LD rd=RAM[imm[MAW-1:0]]                      9 JZ if zero: pc=imm, else pc=pc+1
//   10-15 NOP: no writes, flags unchanged, pc=pc+1, still retires after 3 cycles.
//  Flags: zero=(res==0) for ops 0-6 and 8; carry written only by ADD/SUB, otherwise held. ST/JZ/NOP hold both.
//  PC: pc=pc+1 at WB for every op except taken JZ; wraps 2**DW-1 -> 0.
//  RAM address uses low MAW bits of imm only (upper bits ignored, aliasing by design).
//  rd==rs legal: operands sampled in DECODE, write in WB; no hazard (one instruction in flight).
//  dbg_data reflects the register write from the cycle after WB.
//  RESET mid-instruction: aborts immediately, no register/RAM/pc update; instr in flight discarded.
// TESTING
//  1 Reset then LDI r1=0x05, LDI r2=0x03, ADD r1,r2 -> dbg r1=0x08, zero=0, carry=0, pc=3; retire 3 cycles after each accept.
//  2 LDI r0=0xFF, LDI r1=0x01, ADD r0,r1 -> r0=0x00, zero=1, carry=1; then SUB r1,r0 -> r1=0x01, carry=0.
//  3 LDI r3=0xAA, ST r3,imm=0x12 (DEPTH16 -> addr 2), LD r0,imm=0x02 -> r0=0xAA, retire 4 cycles after accept.
//  4 SUB to zero then JZ imm=0x40 -> pc=0x40; JZ with zero=0 -> pc+1; run 256 NOPs from pc=0xFF start -> pc wraps to 0.
//  5 SRL rs=0x80 imm=7 -> 0x01; imm=3 -> 0x10; opcode 0xF NOP -> regs/flags unchanged, pc+1.
//  6 Hold instr_valid high while busy: exactly one accept per IDLE; assert RESET during EXEC of ADD -> regs=0, pc=0, no retire.

Source files
------------

// File: rtl/acc_cpu_core.sv
// Multicycle register-file CPU core with a valid/ready instruction port.
// Stages: IDLE -> DECODE -> EXEC -> [MEM] -> WB; one instruction in flight.
module acc_cpu_core #(
    parameter int DW        = 8,
    parameter int NREG      = 4,
    parameter int RAM_DEPTH = 16,
    localparam int RAW      = $clog2(NREG),
    localparam int MAW      = $clog2(RAM_DEPTH),
    localparam int IW       = 4 + 2 * RAW + DW,
    localparam int SW       = $clog2(DW)
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic [IW-1:0]  instr,
    input  logic           instr_valid,
    output logic           instr_ready,
    output logic [DW-1:0]  pc,
    output logic           zero,
    output logic           carry,
    output logic           busy,
    output logic           retire,
    input  logic [RAW-1:0] dbg_sel,
    output logic [DW-1:0]  dbg_data
);

    localparam logic [3:0] OP_LDI = 4'd0;
    localparam logic [3:0] OP_MOV = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_ST  = 4'd7;
    localparam logic [3:0] OP_LD  = 4'd8;
    localparam logic [3:0] OP_JZ  = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t state, state_nx;

    logic [IW-1:0]  ir;
    logic [DW-1:0]  regs [NREG];
    logic [DW-1:0]  ram [RAM_DEPTH];
    logic [DW-1:0]  a_q, b_q, res_q, ram_q;
    logic           c_q;
    logic [DW-1:0]  res_c;
    logic           c_c;
    logic [DW-1:0]  wb_val;
    logic           wr_en;

    logic [3:0]     op;
    logic [RAW-1:0] rd, rs;
    logic [DW-1:0]  imm;
    logic [MAW-1:0] addr;

    assign op   = ir[IW-1 -: 4];
    assign rd   = ir[DW+2*RAW-1 -: RAW];
    assign rs   = ir[DW+RAW-1 -: RAW];
    assign imm  = ir[DW-1:0];
    assign addr = imm[MAW-1:0];

    assign instr_ready = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign dbg_data    = regs[dbg_sel];

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (instr_valid) state_nx = S_DECODE;
            S_DECODE: state_nx = S_EXEC;
            S_EXEC:   state_nx = (op == OP_LD) ? S_MEM : S_WB;
            S_MEM:    state_nx = S_WB;
            S_WB:     state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        res_c = '0;
        c_c   = 1'b0;
        unique case (op)
            OP_LDI:  res_c = imm;
            OP_MOV:  res_c = b_q;
            OP_ADD:  {c_c, res_c} = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB:  begin
                res_c = a_q - b_q;
                c_c   = (a_q < b_q);
            end
            OP_AND:  res_c = a_q & b_q;
            OP_OR:   res_c = a_q | b_q;
            OP_SRL:  res_c = b_q >> imm[SW-1:0];
            default: res_c = '0;
        endcase
    end

    assign wb_val = (op == OP_LD) ? ram_q : res_q;
    assign wr_en  = (op <= OP_SRL) || (op == OP_LD);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= S_IDLE;
            ir     <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            c_q    <= 1'b0;
            pc     <= '0;
            zero   <= 1'b0;
            carry  <= 1'b0;
            retire <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            state  <= state_nx;
            retire <= (state == S_WB);
            if (state == S_IDLE && instr_valid) ir <= instr;
            if (state == S_DECODE) begin
                a_q <= regs[rd];
                b_q <= regs[rs];
            end
            if (state == S_EXEC) begin
                res_q <= res_c;
                c_q   <= c_c;
            end
            // All architectural state commits here so an abort leaves none
            if (state == S_WB) begin
                if (wr_en) begin
                    regs[rd] <= wb_val;
                    zero     <= (wb_val == '0);
                end
                if (op == OP_ADD || op == OP_SUB) carry <= c_q;
                if (op == OP_JZ && zero) pc <= imm;
                else                     pc <= pc + DW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (state == S_WB && op == OP_ST && !RESET) ram[addr] <= a_q;
        if (state == S_MEM) ram_q <= ram[addr];
    end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed testbench for acc_cpu_core (DW=8, NREG=4, RAM_DEPTH=16).
module tb_acc_cpu_core;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  pc;
    logic        zero, carry, busy, retire;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;

    int checks   = 0;
    int failures = 0;

    acc_cpu_core #(.DW(8), .NREG(4), .RAM_DEPTH(16)) dut (
        .CLK(CLK), .RESET(RESET), .instr(instr),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc(pc), .zero(zero), .carry(carry), .busy(busy),
        .retire(retire), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ins(input logic [3:0] op,
                                        input logic [1:0] rd,
                                        input logic [1:0] rs,
                                        input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic issue(input logic [15:0] w, input int lat,
                         input string tag);
        int n;
        int got;
        @(negedge CLK);
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        instr       = w;
        instr_valid = 1'b1;
        @(posedge CLK);
        #1 instr_valid = 1'b0;
        got = 0;
        for (n = 1; n <= 10; n++) begin
            @(posedge CLK);
            #1;
            if (retire) begin
                got = n;
                break;
            end
        end
        check({tag, "_lat"}, got, lat);
    endtask

    task automatic chkreg(input string tag, input logic [1:0] s,
                          input logic [7:0] exp);
        dbg_sel = s;
        #1;
        check(tag, dbg_data, exp);
    endtask

    initial begin
        int acc;
        int ret;
        int bad;
        RESET       = 1'b1;
        instr       = '0;
        instr_valid = 1'b0;
        dbg_sel     = '0;
        #12;
        check("rst_pc", pc, 0);
        check("rst_zero", zero, 0);
        check("rst_carry", carry, 0);
        check("rst_ready", instr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_retire", retire, 0);
        for (int i = 0; i < 4; i++) chkreg("rst_reg", 2'(i), 8'h00);
        @(negedge CLK);
        RESET = 1'b0;

        // 1: basic add
        issue(ins(4'd0, 2'd1, 2'd0, 8'h05), 3, "ldi1");
        issue(ins(4'd0, 2'd2, 2'd0, 8'h03), 3, "ldi2");
        issue(ins(4'd2, 2'd1, 2'd2, 8'h00), 3, "add1");
        chkreg("t1_r1", 2'd1, 8'h08);
        check("t1_zero", zero, 0);
        check("t1_carry", carry, 0);
        check("t1_pc", pc, 8'h03);

        // 2: carry out and borrow
        issue(ins(4'd0, 2'd0, 2'd0, 8'hFF), 3, "ldi3");
        issue(ins(4'd0, 2'd1, 2'd0, 8'h01), 3, "ldi4");
        issue(ins(4'd2, 2'd0, 2'd1, 8'h00), 3, "add2");
        chkreg("t2_r0", 2'd0, 8'h00);
        check("t2_zero", zero, 1);
        check("t2_carry", carry, 1);
        issue(ins(4'd3, 2'd1, 2'd0, 8'h00), 3, "sub1");
        chkreg("t2_r1", 2'd1, 8'h01);
        check("t2_carry2", carry, 0);
        check("t2_zero2", zero, 0);

        // 3: store/load with address aliasing
        issue(ins(4'd0, 2'd3, 2'd0, 8'hAA), 3, "ldi5");
        issue(ins(4'd7, 2'd3, 2'd0, 8'h12), 3, "st");
        issue(ins(4'd8, 2'd0, 2'd0, 8'h02), 4, "ld");
        chkreg("t3_r0", 2'd0, 8'hAA);
        check("t3_zero", zero, 0);
        check("t3_pc", pc, 8'h0A);

        // 4: conditional jumps and pc wrap
        issue(ins(4'd3, 2'd3, 2'd3, 8'h00), 3, "sub2");
        check("t4_zero", zero, 1);
        issue(ins(4'd9, 2'd0, 2'd0, 8'h40), 3, "jz1");
        check("t4_jz_taken", pc, 8'h40);
        issue(ins(4'd0, 2'd2, 2'd0, 8'h07), 3, "ldi6");
        issue(ins(4'd9, 2'd0, 2'd0, 8'h10), 3, "jz2");
        check("t4_jz_not", pc, 8'h42);
        issue(ins(4'd0, 2'd0, 2'd0, 8'h00), 3, "ldi7");
        issue(ins(4'd9, 2'd0, 2'd0, 8'hFF), 3, "jz3");
        check("t4_pc_ff", pc, 8'hFF);
        issue(ins(4'd10, 2'd1, 2'd2, 8'h33), 3, "nop0");
        check("t4_wrap", pc, 8'h00);
        for (int i = 1; i < 256; i++)
            issue(ins(4'(10 + i % 6), 2'(i), 2'(i), 8'(i)), 3, "nopN");
        check("t4_pc_256", pc, 8'hFF);
        check("t4_zero_hold", zero, 1);
        check("t4_carry_hold", carry, 0);
        chkreg("t4_r0", 2'd0, 8'h00);
        chkreg("t4_r3", 2'd3, 8'h00);

        // 5: logical shift, flag hold, NOP 0xF
        issue(ins(4'd0, 2'd1, 2'd0, 8'h80), 3, "ldi8");
        issue(ins(4'd0, 2'd0, 2'd0, 8'hFF), 3, "ldi9");
        issue(ins(4'd2, 2'd0, 2'd1, 8'h00), 3, "add3");
        chkreg("t5_r0", 2'd0, 8'h7F);
        check("t5_carry", carry, 1);
        issue(ins(4'd6, 2'd2, 2'd1, 8'h07), 3, "srl1");
        chkreg("t5_srl7", 2'd2, 8'h01);
        issue(ins(4'd6, 2'd3, 2'd1, 8'h0B), 3, "srl2");
        chkreg("t5_srl3", 2'd3, 8'h10);
        check("t5_carry_hold", carry, 1);
        check("t5_zero", zero, 0);
        issue(ins(4'd15, 2'd3, 2'd1, 8'h00), 3, "nopF");
        chkreg("t5_nop_r3", 2'd3, 8'h10);
        chkreg("t5_nop_r1", 2'd1, 8'h80);
        check("t5_nop_carry", carry, 1);
        check("t5_nop_zero", zero, 0);
        check("t5_nop_pc", pc, 8'h05);

        // 6: held valid, then reset mid-EXEC
        issue(ins(4'd0, 2'd0, 2'd0, 8'h01), 3, "ldi10");
        issue(ins(4'd0, 2'd1, 2'd0, 8'h02), 3, "ldi11");
        @(negedge CLK);
        instr       = ins(4'd2, 2'd0, 2'd1, 8'h00);
        instr_valid = 1'b1;
        acc = 0;
        ret = 0;
        bad = 0;
        repeat (8) begin
            if (instr_ready && instr_valid) acc++;
            if (busy == instr_ready) bad++;
            @(posedge CLK);
            #1;
            if (retire) ret++;
            @(negedge CLK);
        end
        instr_valid = 1'b0;
        check("t6_accepts", acc, 2);
        check("t6_retires", ret, 2);
        check("t6_ready_busy", bad, 0);
        chkreg("t6_r0", 2'd0, 8'h05);
        check("t6_pc", pc, 8'h09);

        @(negedge CLK);
        instr       = ins(4'd2, 2'd0, 2'd1, 8'h00);
        instr_valid = 1'b1;
        @(posedge CLK);
        #1 instr_valid = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("t6_busy_exec", busy, 1);
        RESET = 1'b1;
        #1;
        check("t6_rst_pc", pc, 0);
        check("t6_rst_retire", retire, 0);
        check("t6_rst_busy", busy, 0);
        for (int i = 0; i < 4; i++) chkreg("t6_rst_reg", 2'(i), 8'h00);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        ret = 0;
        repeat (5) begin
            @(posedge CLK);
            #1;
            if (retire) ret++;
        end
        check("t6_no_retire", ret, 0);
        check("t6_ready", instr_ready, 1);
        issue(ins(4'd0, 2'd2, 2'd0, 8'h33), 3, "ldi12");
        chkreg("t6_post_r2", 2'd2, 8'h33);
        check("t6_post_pc", pc, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1);
    end

endmodule
